instr_mem_responder: RTL
========================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 1, meaning extra memory wait states per access (legal 0..7).
REQ-002 SHALL have parameter DEPTH, default 2, meaning response FIFO entries (legal 2 or 4).
REQ-003 SHALL have parameter MEM_WORDS, default 4096, meaning number of implemented 32-bit words.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, reset that is asynchronous and active-low.
REQ-006 SHALL have port req_i, input, 1, fetch request valid.
REQ-007 SHALL have port addr_i, input, 32, fetch byte address.
REQ-008 SHALL have port gnt_o, output, 1, request accepted this cycle.
REQ-009 SHALL have port flush_i, input, 1, jump or flush from the fetch side.
REQ-010 SHALL have port rvalid_o, input-facing output, 1, response available.
REQ-011 SHALL have port rready_i, input, 1, fetch side consumes the response.
REQ-012 SHALL have port rdata_o, output, 32, instruction word.
REQ-013 SHALL have port raddr_o, output, 32, word-aligned address of the response.
REQ-014 SHALL have port rerr_o, output, 1, response address out of range.
REQ-015 SHALL have port mem_en_o, output, 1, synchronous SRAM read enable.
REQ-016 SHALL have port mem_addr_o, output, 30, SRAM word address.
REQ-017 SHALL have port mem_rdata_i, input, 32, SRAM data, held stable from one cycle after mem_en_o until the next mem_en_o.

Function
REQ-018 SHALL implement the FSM states IDLE and WAIT, with a 3-bit wait counter.
REQ-019 SHALL drive gnt_o = req_i & ~flush_i & (state==IDLE | capture) & (count + capture - pop < DEPTH), where capture = (state==WAIT & counter==0) and pop = rvalid_o & rready_i.
REQ-020 SHALL, on grant, assert mem_en_o in the same cycle, drive mem_addr_o = addr_i[31:2], latch {addr_i[31:2],2'b00}, load counter = WAIT_CYCLES, and go to WAIT.
REQ-021 SHALL ignore addr_i[1:0]; every access is a full aligned word.
REQ-022 SHALL, in WAIT with counter!=0, decrement the counter and keep mem_en_o low.
REQ-023 SHALL, in the capture cycle, push {mem_rdata_i, latched address, err} into the FIFO and go to IDLE, or re-enter WAIT if it grants again in that same cycle.
REQ-024 SHALL set err when the latched word index is >= MEM_WORDS, and push data 32'h00000013 (NOP) in place of mem_rdata_i; mem_en_o is still asserted for such accesses.
REQ-025 SHALL make the first response visible WAIT_CYCLES+2 cycles after the grant edge, i.e. rvalid_o is high in the cycle after capture.
REQ-026 SHALL drive rvalid_o = FIFO not empty, and drive rdata_o, raddr_o and rerr_o from the FIFO head; head outputs are stable while rvalid_o & ~rready_i.
REQ-027 SHALL allow a simultaneous push and pop when the FIFO is full, with the count unchanged.
REQ-028 SHALL have FIFO pointers wrap modulo DEPTH; no push ever occurs while full, because grant is gated per REQ-019.
REQ-029 SHALL, on flush_i, empty the FIFO next cycle, return to IDLE, drop the in-flight capture, and force gnt_o=0 that cycle; rvalid_o SHALL be low in the following cycle.
REQ-030 SHALL give flush_i priority over capture, push and pop in the same cycle.
REQ-031 SHALL keep responses in grant order, with at most one memory access outstanding.

Reset
REQ-032 SHALL, while rst_ni is low, immediately force state=IDLE, counter=0, FIFO empty, and outputs gnt_o=0, rvalid_o=0, mem_en_o=0, rdata_o=0, raddr_o=0, rerr_o=0.
REQ-033 SHALL, on reset assertion mid-access, discard the access; no response appears after release.
REQ-034 SHALL allow a grant in the first clock edge after rst_ni rises if req_i is high.

Verification
REQ-035 SHALL be verified with WAIT_CYCLES=1: req_i with addr_i=0x0000_0106 -> mem_addr_o=0x41, rvalid_o 3 cycles after grant, raddr_o=0x0000_0104, rdata_o=SRAM[0x41].
REQ-036 SHALL be verified with WAIT_CYCLES=0, rready_i=1, req_i held over addresses 0,4,8,12 -> a grant every cycle after the first and 4 in-order responses.
REQ-037 SHALL be verified with rready_i=0 and DEPTH=2 -> exactly 2 grants, then gnt_o=0; raising rready_i for one cycle -> one pop and exactly one further grant.
REQ-038 SHALL be verified with flush_i asserted during WAIT and 1 entry queued -> rvalid_o=0 next cycle, no stale response, and the next request returns only its own data.
REQ-039 SHALL be verified with addr_i=MEM_WORDS*4 -> response rerr_o=1, rdata_o=0x00000013.
REQ-040 SHALL be verified with rst_ni dropped asynchronously mid-WAIT -> all outputs 0 before the next edge, and no response after release.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: fronts a synchronous SRAM with a fixed wait-state access
// and a small in-order response FIFO; out-of-range fetches return a flagged NOP.
module instr_mem_responder #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned MEM_WORDS   = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [31:0] addr_i,
  output logic        gnt_o,
  input  logic        flush_i,
  output logic        rvalid_o,
  input  logic        rready_i,
  output logic [31:0] rdata_o,
  output logic [31:0] raddr_o,
  output logic        rerr_o,
  output logic        mem_en_o,
  output logic [29:0] mem_addr_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PtrW = (DEPTH > 2) ? 2 : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [31:0] Nop  = 32'h0000_0013;

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [2:0]      wcnt_q, wcnt_d;
  logic [29:0]     acc_addr_q, acc_addr_d;
  logic            acc_err_q, acc_err_d;
  logic [31:0]     fdata_q [DEPTH];
  logic [31:0]     fdata_d [DEPTH];
  logic [29:0]     faddr_q [DEPTH];
  logic [29:0]     faddr_d [DEPTH];
  logic            ferr_q  [DEPTH];
  logic            ferr_d  [DEPTH];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic capture, pop, push, room, gnt;
  logic unused_addr;

  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    capture  = (state_q == StWait) && (wcnt_q == 3'd0);
    rvalid_o = (count_q != '0);
    pop      = rvalid_o & rready_i;
    // Room is judged after this cycle's capture and pop, so a grant never overfills.
    room     = (32'(count_q) + 32'(capture) - 32'(pop)) < DEPTH;
    gnt      = req_i & ~flush_i & ((state_q == StIdle) | capture) & room;
    push     = capture & ~flush_i;
  end

  // Reset must hold the combinational grant low even while req_i is high.
  assign gnt_o      = gnt & rst_ni;
  assign mem_en_o   = gnt_o;
  assign mem_addr_o = addr_i[31:2];
  assign rdata_o    = rvalid_o ? fdata_q[rptr_q] : '0;
  assign raddr_o    = rvalid_o ? {faddr_q[rptr_q], 2'b00} : '0;
  assign rerr_o     = rvalid_o ? ferr_q[rptr_q] : 1'b0;

  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    acc_addr_d = acc_addr_q;
    acc_err_d  = acc_err_q;
    fdata_d    = fdata_q;
    faddr_d    = faddr_q;
    ferr_d     = ferr_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;

    if (flush_i) begin
      state_d = StIdle;
      wcnt_d  = 3'd0;
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if ((state_q == StWait) && (wcnt_q != 3'd0)) begin
        wcnt_d = wcnt_q - 3'd1;
      end
      if (capture) begin
        state_d = StIdle;
      end
      if (gnt) begin
        state_d    = StWait;
        wcnt_d     = 3'(WAIT_CYCLES);
        acc_addr_d = addr_i[31:2];
        acc_err_d  = 32'(addr_i[31:2]) >= MEM_WORDS;
      end
      if (push) begin
        fdata_d[wptr_q] = acc_err_q ? Nop : mem_rdata_i;
        faddr_d[wptr_q] = acc_addr_q;
        ferr_d[wptr_q]  = acc_err_q;
        wptr_d          = wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PtrW'(1);
      end
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      wcnt_q     <= 3'd0;
      acc_addr_q <= '0;
      acc_err_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fdata_q[i] <= '0;
        faddr_q[i] <= '0;
        ferr_q[i]  <= 1'b0;
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      acc_addr_q <= acc_addr_d;
      acc_err_q  <= acc_err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      fdata_q    <= fdata_d;
      faddr_q    <= faddr_d;
      ferr_q     <= ferr_d;
    end
  end

endmodule
